// File: rtl/mul_pipe_if.sv
// mul_pipe_if: request/result handshake bundle for mul_pipe; acc fields exist only with MUL_PIPE_ACC_EN
interface mul_pipe_if #(parameter int DATA_W = 32, parameter int TAG_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_signed;
  logic [TAG_W-1:0]  in_tag;
`ifdef MUL_PIPE_ACC_EN
  logic [1:0]        in_acc_op;
  logic [DATA_W-1:0] in_acc_hi;
  logic [DATA_W-1:0] in_acc_lo;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_hi;
  logic [DATA_W-1:0] out_lo;
  logic [TAG_W-1:0]  out_tag;
  modport master (
`ifdef MUL_PIPE_ACC_EN
    output in_acc_op, in_acc_hi, in_acc_lo,
`endif
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_tag
  );
  modport slave (
`ifdef MUL_PIPE_ACC_EN
    input  in_acc_op, in_acc_hi, in_acc_lo,
`endif
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_tag
  );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined signed/unsigned multiplier with tag sideband and global stall/flush.
// MUL_PIPE_ACC_EN adds a trailing MADD/MSUB stage (latency STAGES+1).
module mul_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 5,
  parameter int TAG_W  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  output logic         busy_o,
  mul_pipe_if.slave    bus
);
  localparam int P = 2 * DATA_W;
  logic              adv, take;
  logic [P-1:0]      a_x, b_x, prod;
  logic [STAGES-1:0] v_q, v_d;
  logic [P-1:0]      p_q [STAGES];
  logic [P-1:0]      p_d [STAGES];
  logic [TAG_W-1:0]  t_q [STAGES];
  logic [TAG_W-1:0]  t_d [STAGES];
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv & ~flush_i;
  assign take         = bus.in_valid & bus.in_ready;
  // extending to the full product width yields the same low 2*DATA_W bits as the DATA_W+1 signed product
  assign a_x  = {{DATA_W{bus.in_signed & bus.in_a[DATA_W-1]}}, bus.in_a};
  assign b_x  = {{DATA_W{bus.in_signed & bus.in_b[DATA_W-1]}}, bus.in_b};
  assign prod = a_x * b_x;
`ifdef MUL_PIPE_ACC_EN
  logic [1:0]       o_q [STAGES];
  logic [1:0]       o_d [STAGES];
  logic [P-1:0]     c_q [STAGES];
  logic [P-1:0]     c_d [STAGES];
  logic             ov_q;
  logic [P-1:0]     r_q;
  logic [TAG_W-1:0] rt_q;
  always_comb begin
    o_d[0] = bus.in_acc_op;
    c_d[0] = {bus.in_acc_hi, bus.in_acc_lo};
    for (int i = 1; i < STAGES; i++) begin
      o_d[i] = o_q[i-1];
      c_d[i] = c_q[i-1];
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      o_q <= '{default: '0};
      c_q <= '{default: '0};
    end else if (!flush_i && adv) begin
      o_q <= o_d;
      c_q <= c_d;
    end
  always_ff @(posedge clk)
    if (reset) begin
      ov_q <= 1'b0;
      r_q  <= '0;
      rt_q <= '0;
    end else if (flush_i) begin
      ov_q <= 1'b0;
    end else if (adv) begin
      ov_q <= v_q[STAGES-1];
      r_q  <= o_q[STAGES-1] == 2'b01 ? c_q[STAGES-1] + p_q[STAGES-1] :
              o_q[STAGES-1] == 2'b10 ? c_q[STAGES-1] - p_q[STAGES-1] : p_q[STAGES-1];
      rt_q <= t_q[STAGES-1];
    end
  assign bus.out_valid           = ov_q;
  assign {bus.out_hi, bus.out_lo} = r_q;
  assign bus.out_tag             = rt_q;
  assign busy_o                  = |v_q | ov_q;
`else
  assign bus.out_valid           = v_q[STAGES-1];
  assign {bus.out_hi, bus.out_lo} = p_q[STAGES-1];
  assign bus.out_tag             = t_q[STAGES-1];
  assign busy_o                  = |v_q;
`endif
  always_comb begin
    v_d[0] = take;
    p_d[0] = prod;
    t_d[0] = bus.in_tag;
    for (int i = 1; i < STAGES; i++) begin
      v_d[i] = v_q[i-1];
      p_d[i] = p_q[i-1];
      t_d[i] = t_q[i-1];
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      v_q <= '0;
      p_q <= '{default: '0};
      t_q <= '{default: '0};
    end else if (flush_i) begin
      v_q <= '0;
    end else if (adv) begin
      v_q <= v_d;
      p_q <= p_d;
      t_q <= t_d;
    end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed bench for mul_pipe (DATA_W=32, STAGES=5, TAG_W=8).
module tb_mul_pipe;
`ifdef MUL_PIPE_ACC_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int checks = 0;
  int errors = 0;
  mul_pipe_if #(.DATA_W(32), .TAG_W(8)) bus ();
  mul_pipe #(.DATA_W(32), .STAGES(5), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .busy_o(busy), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [7:0] tg);
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_tag    = tg;
`ifdef MUL_PIPE_ACC_EN
    bus.in_acc_op = 2'b00;
    bus.in_acc_hi = '0;
    bus.in_acc_lo = '0;
`endif
  endtask

  // called one cycle after the accepting edge; result must appear exactly LAT cycles after accept
  task automatic expect_op(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [7:0] tg);
    for (int i = 1; i < LAT; i++) begin
      chk({tag, " early valid"}, 64'(bus.out_valid), 64'd0);
      tick();
    end
    chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, " hi"}, 64'(bus.out_hi), 64'(hi));
    chk({tag, " lo"}, 64'(bus.out_lo), 64'(lo));
    chk({tag, " tag"}, 64'(bus.out_tag), 64'(tg));
    tick();
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [7:0] tg, input logic [31:0] hi, input logic [31:0] lo);
    drive(1'b1, a, b, s, tg);
    #1;
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    expect_op(tag, hi, lo, tg);
  endtask

  initial begin
    int sent, recv;
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_hi", 64'(bus.out_hi), 64'd0);
    chk("reset out_lo", 64'(bus.out_lo), 64'd0);
    chk("reset out_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;
    tick();

    op("s -1*2", 32'hFFFF_FFFF, 32'h2, 1'b1, 8'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    op("u max*2", 32'hFFFF_FFFF, 32'h2, 1'b0, 8'h12, 32'h0000_0001, 32'hFFFF_FFFE);
    op("s min*min", 32'h8000_0000, 32'h8000_0000, 1'b1, 8'h13, 32'h4000_0000, 32'h0);
    op("s -3*5", 32'hFFFF_FFFD, 32'h5, 1'b1, 8'h14, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op("u max*max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 8'h15, 32'hFFFF_FFFE, 32'h0000_0001);
    op("s max*max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 8'h16, 32'h3FFF_FFFF, 32'h0000_0001);

    // 8 back-to-back ops, tag k carries a=k, b=0x100; WB stalls during cycles 6..9
    sent = 0;
    recv = 0;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = !(c >= 6 && c <= 9);
      drive(sent < 8, 32'(sent + 1), 32'h100, 1'b0, 8'(sent + 1));
      #1;
      if (bus.out_valid) begin
        chk("bp tag", 64'(bus.out_tag), 64'(recv + 1));
        chk("bp lo", 64'(bus.out_lo), 64'((recv + 1) * 256));
        chk("bp hi", 64'(bus.out_hi), 64'd0);
        if (!bus.out_ready) chk("bp stall in_ready", 64'(bus.in_ready), 64'd0);
        else recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.out_ready = 1'b1;
    chk("bp sent", 64'(sent), 64'd8);
    chk("bp received", 64'(recv), 64'd8);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(k + 1), 32'h3, 1'b0, 8'(8'h21 + k));
      tick();
    end
    drive(1'b1, 32'h9, 32'h9, 1'b0, 8'h24);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(bus.in_ready), 64'd0);
    chk("flush busy before", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, '0);
    chk("flush busy after", 64'(busy), 64'd0);
    chk("flush out_valid after", 64'(bus.out_valid), 64'd0);
    op("post-flush", 32'h7, 32'h6, 1'b0, 8'h25, 32'h0, 32'd42);

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1234_5678, 32'(k + 3), 1'b0, 8'(8'h41 + k));
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst out_hi", 64'(bus.out_hi), 64'd0);
    chk("midrst out_lo", 64'(bus.out_lo), 64'd0);
    chk("midrst out_tag", 64'(bus.out_tag), 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk("midrst nothing emerges", 64'(bus.out_valid), 64'd0);
      tick();
    end

`ifdef MUL_PIPE_ACC_EN
    drive(1'b1, 32'h3, 32'h2, 1'b0, 8'h31);
    bus.in_acc_op = 2'b10;
    bus.in_acc_lo = 32'h5;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    expect_op("msub 5-6", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h31);
    drive(1'b1, 32'h3, 32'h2, 1'b0, 8'h32);
    bus.in_acc_op = 2'b01;
    bus.in_acc_hi = 32'h1;
    bus.in_acc_lo = 32'hFFFF_FFFF;
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    expect_op("madd carry", 32'h2, 32'h5, 8'h32);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
